// File: rtl/instr_sequencer.sv
// Instruction state sequencer: fetch, opcode decode, execute, retire count.
// Optional single-step hold at FETCH1 under INSTR_SEQUENCER_STEP_EN.
module instr_sequencer #(
  parameter int CNT_W = 16,
  parameter int OPC_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [OPC_W-1:0] opcode,
`ifdef INSTR_SEQUENCER_STEP_EN
  input  logic             step_mode,
  input  logic             step,
`endif
  output logic [5:0]       state,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [5:0] {
    S_IDLE = 6'd0,
    S_F1   = 6'd1,  S_F2   = 6'd2,  S_F3   = 6'd3,
    S_F4   = 6'd4,  S_F5   = 6'd5,  S_F6   = 6'd6,
    S_L11  = 6'd7,  S_L12  = 6'd8,  S_L13  = 6'd9,  S_L14 = 6'd10,
    S_L21  = 6'd11, S_L22  = 6'd12, S_L23  = 6'd13, S_L24 = 6'd14,
    S_ST1  = 6'd15, S_ST2  = 6'd16, S_ST3  = 6'd17, S_ST4 = 6'd18,
    S_ADD1 = 6'd19, S_ADD2 = 6'd20,
    S_MUL1 = 6'd21, S_MUL2 = 6'd22,
    S_FIN  = 6'd23
  } state_e;

  localparam logic [OPC_W-1:0] OP_NOP = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_LD1 = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_LD2 = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_STA = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_MUL = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_END = OPC_W'(15);

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ill_q, ill_d;
  logic             start_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             f1_go;

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef INSTR_SEQUENCER_STEP_EN
  assign f1_go = !step_mode || step;
`else
  assign f1_go = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ill_d   = ill_q;
    case (state_q)
      S_IDLE: begin
        if (start && !start_q) begin
          state_d = S_F1;
          cnt_d   = '0;
          ill_d   = 1'b0;
        end
      end
      S_F1: begin
        if (f1_go) state_d = S_F2;
      end
      S_F2, S_F3, S_F4, S_F5,
      S_L11, S_L12, S_L13,
      S_L21, S_L22, S_L23,
      S_ST1, S_ST2, S_ST3,
      S_ADD1, S_MUL1: begin
        state_d = state_e'(state_q + 6'd1);
      end
      S_F6: begin
        if (opcode == OP_LD1)      state_d = S_L11;
        else if (opcode == OP_LD2) state_d = S_L21;
        else if (opcode == OP_STA) state_d = S_ST1;
        else if (opcode == OP_ADD) state_d = S_ADD1;
        else if (opcode == OP_MUL) state_d = S_MUL1;
        else if (opcode == OP_NOP) begin
          state_d = S_F1;
          cnt_d   = cnt_inc;
        end else if (opcode == OP_END) begin
          state_d = S_FIN;
        end else begin
          state_d = S_FIN;
          ill_d   = 1'b1;
        end
      end
      S_L14, S_L24, S_ST4, S_ADD2, S_MUL2: begin
        state_d = S_F1;
        cnt_d   = cnt_inc;
      end
      S_FIN: begin
        // hold off re-entry until start has been released
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE) && (state_d != S_FIN);
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
      start_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
      start_q <= start;
      cnt_q   <= cnt_d;
    end
  end

  assign state       = state_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign illegal     = ill_q;
  assign instr_count = cnt_q;

endmodule
